// File: rtl/bus_responder.sv
// CPU-side bus responder: mirrored RAM, serial pad port and an interval timer with IRQ.
// Reads are combinational in the address cycle; writes and read side effects commit on the clk edge.
module bus_responder #(
  parameter int RAM_BITS = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic        rw,
  input  logic        sync,
  input  logic [7:0]  d_in,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic [7:0]  pad_buttons,
  output logic        irq_n
);

  localparam logic [15:0] PAD_ADDR = 16'h4016;
  localparam logic [15:0] RLD_ADDR = 16'h4020;
  localparam logic [15:0] CTL_ADDR = 16'h4021;
  localparam logic [15:0] CNT_ADDR = 16'h4022;

  logic [7:0] ram [2**RAM_BITS];

  logic       strobe;
  logic [7:0] sr;
  logic [7:0] reload;
  logic [7:0] count;
  logic       enable;
  logic       irq_en;
  logic       flag;

  logic       sel_ram;
  logic       sel_pad;
  logic       sel_rld;
  logic       sel_ctl;
  logic       sel_cnt;
  logic       mapped;

  logic [7:0] count_nxt;
  logic       enable_nxt;
  logic       irq_en_nxt;
  logic       flag_nxt;

  // The opcode-fetch marker carries no decode meaning here.
  logic unused_sync;
  assign unused_sync = sync;

  assign sel_ram = (a[15:13] == 3'b000);
  assign sel_pad = (a == PAD_ADDR);
  assign sel_rld = (a == RLD_ADDR);
  assign sel_ctl = (a == CTL_ADDR);
  assign sel_cnt = (a == CNT_ADDR);
  assign mapped  = sel_ram | sel_pad | sel_rld | sel_ctl | sel_cnt;

  always_comb begin
    d_out = 8'hFF;
    if (sel_ram)      d_out = ram[a[RAM_BITS-1:0]];
    else if (sel_pad) d_out = {7'b0, sr[0]};
    else if (sel_rld) d_out = reload;
    else if (sel_ctl) d_out = {flag, 5'b0, irq_en, enable};
    else if (sel_cnt) d_out = count;
  end

  assign d_oe = rw & mapped;

  // Expiry is applied after the read-clear so a same-edge set keeps the flag high.
  always_comb begin
    count_nxt  = count;
    enable_nxt = enable;
    irq_en_nxt = irq_en;
    flag_nxt   = flag;
    if (rw && sel_ctl) flag_nxt = 1'b0;
    if (!rw && sel_ctl) begin
      enable_nxt = d_in[0];
      irq_en_nxt = d_in[1];
    end
    if (enable) begin
      if (count == 8'd0) begin
        count_nxt = reload;
        flag_nxt  = 1'b1;
      end else begin
        count_nxt = count - 8'd1;
      end
    end else if (enable_nxt) begin
      count_nxt = reload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      strobe <= 1'b0;
      sr     <= 8'hFF;
      reload <= 8'd0;
      count  <= 8'd0;
      enable <= 1'b0;
      irq_en <= 1'b0;
      flag   <= 1'b0;
      irq_n  <= 1'b1;
    end else begin
      if (strobe)                  sr <= pad_buttons;
      else if (rw && sel_pad)      sr <= {1'b1, sr[7:1]};
      if (!rw && sel_pad)          strobe <= d_in[0];
      if (!rw && sel_rld)          reload <= d_in;
      count  <= count_nxt;
      enable <= enable_nxt;
      irq_en <= irq_en_nxt;
      flag   <= flag_nxt;
      irq_n  <= ~(flag_nxt & irq_en_nxt);
    end
  end

  // RAM survives reset, but a write presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && !rw && sel_ram) ram[a[RAM_BITS-1:0]] <= d_in;
  end

endmodule

// File: tb/tb_bus_responder.sv
// Directed and randomized checks of bus_responder against a behavioural bus model.
module tb_bus_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic        rw;
  logic        sync;
  logic [7:0]  d_in;
  logic [7:0]  d_out;
  logic        d_oe;
  logic [7:0]  pad_buttons;
  logic        irq_n;

  int errors = 0;
  int checks = 0;

  bus_responder #(.RAM_BITS(11)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .rw          (rw),
    .sync        (sync),
    .d_in        (d_in),
    .d_out       (d_out),
    .d_oe        (d_oe),
    .pad_buttons (pad_buttons),
    .irq_n       (irq_n)
  );

  always #5 clk = ~clk;

  // Reference model: pad is a latched snapshot plus a read index; timer as plain counters.
  logic [7:0] ram_m [2048];
  bit         strobe_m;
  logic [7:0] latch_m;
  int         idx_m;
  logic [7:0] reload_m;
  logic [7:0] count_m;
  bit         en_m, ie_m, flag_m, irq_n_m;

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input logic [15:0] addr, output bit mp);
    mp = 1'b1;
    if (addr < 16'h2000)       return ram_m[addr[10:0]];
    else if (addr == 16'h4016) return (idx_m < 8) ? {7'b0, latch_m[idx_m]} : 8'h01;
    else if (addr == 16'h4020) return reload_m;
    else if (addr == 16'h4021) return {flag_m, 5'b0, ie_m, en_m};
    else if (addr == 16'h4022) return count_m;
    mp = 1'b0;
    return 8'hFF;
  endfunction

  task automatic model_reset();
    strobe_m = 0; latch_m = 8'hFF; idx_m = 8;
    reload_m = 8'd0; count_m = 8'd0;
    en_m = 0; ie_m = 0; flag_m = 0; irq_n_m = 1;
  endtask

  task automatic model_edge(input logic r, input logic [15:0] addr, input logic [7:0] din);
    bit new_en, new_ie, f;
    if (strobe_m) begin
      latch_m = pad_buttons;
      idx_m = 0;
    end else if (r && addr == 16'h4016 && idx_m < 8) begin
      idx_m++;
    end
    if (!r && addr == 16'h4016) strobe_m = din[0];
    if (!r && addr < 16'h2000) ram_m[addr[10:0]] = din;
    new_en = en_m; new_ie = ie_m; f = flag_m;
    if (r && addr == 16'h4021) f = 0;
    if (!r && addr == 16'h4021) begin
      new_en = din[0];
      new_ie = din[1];
    end
    if (en_m) begin
      if (count_m == 0) begin
        count_m = reload_m;
        f = 1;
      end else begin
        count_m = count_m - 1;
      end
    end else if (new_en) begin
      count_m = reload_m;
    end
    if (!r && addr == 16'h4020) reload_m = din;
    en_m = new_en; ie_m = new_ie; flag_m = f;
    irq_n_m = !(flag_m && ie_m);
  endtask

  task automatic step(input logic r, input logic [15:0] addr, input logic [7:0] din,
                      output logic [7:0] rd);
    logic [7:0] exp;
    bit mp;
    @(negedge clk);
    a = addr; rw = r; d_in = din; sync = 1'($urandom_range(0, 1));
    #1;
    exp = model_rd(addr, mp);
    rd = d_out;
    if (r) begin
      check8("d_out", d_out, exp);
      check1("d_oe", d_oe, mp);
    end else begin
      check1("d_oe_on_write", d_oe, 1'b0);
    end
    @(posedge clk);
    model_edge(r, addr, din);
    #1;
    check1("irq_n", irq_n, irq_n_m);
  endtask

  task automatic do_reset(input logic r, input logic [15:0] addr, input logic [7:0] din);
    @(negedge clk);
    rst = 1'b1; a = addr; rw = r; d_in = din;
    @(posedge clk);
    model_reset();
    #1;
    check1("irq_n_reset", irq_n, 1'b1);
    rst = 1'b0; a = 16'h5000; rw = 1'b1; d_in = 8'h00;
  endtask

  logic [7:0]  rd;
  logic [9:0]  pad_seq;
  logic [15:0] ad;
  logic [7:0]  dv;
  logic        r;
  int          sel;

  initial begin
    rst = 1'b1; a = 16'h5000; rw = 1'b1; sync = 1'b0; d_in = 8'h00; pad_buttons = 8'h00;
    model_reset();
    do_reset(1'b1, 16'h5000, 8'h00);

    // Reset state
    step(1'b1, 16'h4021, 8'h00, rd); check8("rst_ctl", rd, 8'h00);
    step(1'b1, 16'h4020, 8'h00, rd); check8("rst_reload", rd, 8'h00);
    step(1'b1, 16'h4022, 8'h00, rd); check8("rst_count", rd, 8'h00);
    step(1'b1, 16'h4016, 8'h00, rd); check8("rst_pad", rd, 8'h01);

    for (int i = 0; i < 2048; i++) step(1'b0, 16'(i), 8'($urandom), rd);

    // RAM mirroring
    step(1'b0, 16'h0123, 8'h5A, rd);
    step(1'b1, 16'h0923, 8'h00, rd); check8("mirror_0923", rd, 8'h5A);
    check1("mirror_d_oe", d_oe, 1'b1);
    step(1'b1, 16'h1923, 8'h00, rd); check8("mirror_1923", rd, 8'h5A);

    // Pad serial readout
    pad_buttons = 8'b1000_0101;
    pad_seq = 10'b11_1000_0101;
    step(1'b0, 16'h4016, 8'h01, rd);
    step(1'b0, 16'h4016, 8'h00, rd);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'h4016, 8'h00, rd);
      check8("pad_seq", rd, {7'b0, pad_seq[i]});
    end

    // Countdown, expiry, read-clear
    do_reset(1'b1, 16'h5000, 8'h00);
    step(1'b0, 16'h4020, 8'h03, rd);
    step(1'b0, 16'h4021, 8'h03, rd);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 16'h4022, 8'h00, rd);
      check8("count_seq", rd, (i == 4) ? 8'd3 : 8'(3 - i));
      if (i == 2) check1("irq_before_expiry", irq_n, 1'b1);
      if (i == 3) check1("irq_at_expiry", irq_n, 1'b0);
    end
    step(1'b1, 16'h4021, 8'h00, rd); check8("ctl_flag", rd, 8'h83);
    check1("irq_after_clear", irq_n, 1'b1);

    // Set beats clear with reload 0
    do_reset(1'b1, 16'h5000, 8'h00);
    step(1'b0, 16'h4020, 8'h00, rd);
    step(1'b0, 16'h4021, 8'h03, rd);
    step(1'b1, 16'h4021, 8'h00, rd); check8("r0_first", rd, 8'h03);
    check1("r0_irq1", irq_n, 1'b0);
    step(1'b1, 16'h4021, 8'h00, rd); check8("r0_second", rd, 8'h83);
    check1("r0_irq2", irq_n, 1'b0);

    // Unmapped access, read-only count, hold while disabled
    do_reset(1'b1, 16'h5000, 8'h00);
    step(1'b0, 16'h4020, 8'h09, rd);
    step(1'b0, 16'h4021, 8'h01, rd);
    step(1'b0, 16'h4021, 8'h00, rd);
    step(1'b1, 16'h4022, 8'h00, rd); check8("hold_count", rd, 8'd8);
    step(1'b0, 16'h4022, 8'h77, rd);
    step(1'b1, 16'h4022, 8'h00, rd); check8("count_ro", rd, 8'd8);
    step(1'b1, 16'h5000, 8'h00, rd); check8("unmapped_dout", rd, 8'hFF);
    check1("unmapped_doe", d_oe, 1'b0);

    // Reset mid-countdown with flag raised and a colliding write
    step(1'b0, 16'h4020, 8'h05, rd);
    step(1'b0, 16'h4021, 8'h03, rd);
    for (int i = 0; i < 7; i++) step(1'b1, 16'h4022, 8'h00, rd);
    check1("irq_pre_reset", irq_n, 1'b0);
    do_reset(1'b0, 16'h4020, 8'h55);
    check1("irq_post_reset", irq_n, 1'b1);
    step(1'b1, 16'h4021, 8'h00, rd); check8("post_rst_ctl", rd, 8'h00);
    step(1'b1, 16'h4016, 8'h00, rd); check8("post_rst_pad", rd, 8'h01);
    step(1'b1, 16'h4020, 8'h00, rd); check8("post_rst_reload", rd, 8'h00);
    step(1'b1, 16'h0123, 8'h00, rd); check8("post_rst_ram", rd, 8'h5A);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    ad = 16'($urandom_range(0, 16'h1FFF));
        2:       ad = 16'h4016;
        3:       ad = 16'h4020;
        4, 5:    ad = 16'h4021;
        6:       ad = 16'h4022;
        7:       ad = 16'($urandom_range(16'h2000, 16'h4015));
        8:       ad = 16'($urandom_range(16'h4023, 16'hFFFF));
        default: ad = 16'h4017;
      endcase
      r  = 1'($urandom_range(0, 1));
      dv = 8'($urandom);
      if ($urandom_range(0, 7) == 0) pad_buttons = 8'($urandom);
      if ($urandom_range(0, 99) == 0) do_reset(r, ad, dv);
      else step(r, ad, dv, rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
